// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate truth-table checker.
// Used by gate_tt_checker and gate_chk_settle_cnt.
package gate_chk_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      DONE   = 3'd4
   } state_e;

   // Truth tables for two-input gates, bit i = Y for stimulus value i = {A,B}
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;

   localparam int SETTLE_W = 4;

endpackage

// File: rtl/gate_chk_settle_cnt.sv
// Loadable down-counter with a zero flag; times the settle window between
// driving a vector and sampling the gate output.
module gate_chk_settle_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         cnt_zero
);

   localparam logic [W-1:0] CNT_ONE = W'(1);

   logic [W-1:0] cnt_r;

   // Counter register: load wins over decrement, decrement stops at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != '0)) begin
         cnt_r <= cnt_r - CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt_zero = (cnt_r == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// On-chip truth-table sweeper for small combinational gates; reports pass,
// mismatch count and first failing vector. GATE_TT_CHK_OBS_TT_EN adds obs_tt.
module gate_tt_checker
   import gate_chk_pkg::*;
#(
   parameter int                   N_IN       = 2,
   parameter logic [(1<<N_IN)-1:0] EXP_TT     = TT_OR,
   parameter int                   SETTLE_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [N_IN-1:0]   stim,
   input  logic              dut_y,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     err_cnt,
   output logic [N_IN-1:0]   fail_idx,
   output logic              fail_vld
`ifdef GATE_TT_CHK_OBS_TT_EN
   ,
   output logic [(1<<N_IN)-1:0] obs_tt
`endif
);

   localparam int                  NV          = 1 << N_IN;
   localparam logic [N_IN-1:0]     IDX_LAST    = N_IN'(NV - 1);
   localparam logic [N_IN-1:0]     IDX_ONE     = N_IN'(1);
   localparam logic [N_IN:0]       ERR_ONE     = (N_IN + 1)'(1);
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

   // Error counter never wraps back to zero on overflow
   function automatic logic [N_IN:0] sat_inc(input logic [N_IN:0] v);
      return (&v) ? v : (v + ERR_ONE);
   endfunction

   state_e          state_r, state_s;
   logic [N_IN-1:0] idx_r, idx_s;
   logic [N_IN-1:0] stim_r, stim_s;
   logic            busy_r, busy_s;
   logic            done_r, done_s;
   logic            pass_r, pass_s;
   logic [N_IN:0]   err_r, err_s;
   logic [N_IN-1:0] fidx_r, fidx_s;
   logic            fvld_r, fvld_s;
   logic            cnt_load_s, cnt_dec_s, cnt_zero_s;
`ifdef GATE_TT_CHK_OBS_TT_EN
   logic [NV-1:0]   obs_r, obs_s;
`endif

   gate_chk_settle_cnt #(.W(SETTLE_W)) u_settle (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load_s),
      .load_val (SETTLE_LOAD),
      .dec      (cnt_dec_s),
      .cnt_zero (cnt_zero_s)
   );

   // Next-state and next-output decode
   always_comb begin
      state_s    = state_r;
      idx_s      = idx_r;
      stim_s     = stim_r;
      busy_s     = busy_r;
      done_s     = 1'b0;
      pass_s     = pass_r;
      err_s      = err_r;
      fidx_s     = fidx_r;
      fvld_s     = fvld_r;
      cnt_load_s = 1'b0;
      cnt_dec_s  = 1'b0;
`ifdef GATE_TT_CHK_OBS_TT_EN
      obs_s      = obs_r;
`endif
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = DRIVE;
               busy_s  = 1'b1;
               pass_s  = 1'b0;
               err_s   = '0;
               fidx_s  = '0;
               fvld_s  = 1'b0;
               idx_s   = '0;
`ifdef GATE_TT_CHK_OBS_TT_EN
               obs_s   = '0;
`endif
            end else begin
               state_s = IDLE;
            end
         end
         DRIVE: begin
            stim_s     = idx_r;
            cnt_load_s = 1'b1;
            state_s    = SETTLE;
         end
         SETTLE: begin
            if (cnt_zero_s) begin
               state_s = SAMPLE;
            end else begin
               cnt_dec_s = 1'b1;
            end
         end
         SAMPLE: begin
`ifdef GATE_TT_CHK_OBS_TT_EN
            obs_s[idx_r] = dut_y;
`endif
            if (dut_y != EXP_TT[idx_r]) begin
               err_s = sat_inc(err_r);
               if (!fvld_r) begin
                  fidx_s = idx_r;
                  fvld_s = 1'b1;
               end else begin
                  fvld_s = fvld_r;
               end
            end else begin
               err_s = err_r;
            end
            // done/pass/busy are set on entry so they are valid during DONE
            if (idx_r == IDX_LAST) begin
               state_s = DONE;
               done_s  = 1'b1;
               busy_s  = 1'b0;
               pass_s  = (err_s == '0);
            end else begin
               idx_s   = idx_r + IDX_ONE;
               state_s = DRIVE;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         idx_r   <= '0;
         stim_r  <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
         err_r   <= '0;
         fidx_r  <= '0;
         fvld_r  <= 1'b0;
`ifdef GATE_TT_CHK_OBS_TT_EN
         obs_r   <= '0;
`endif
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         stim_r  <= stim_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         pass_r  <= pass_s;
         err_r   <= err_s;
         fidx_r  <= fidx_s;
         fvld_r  <= fvld_s;
`ifdef GATE_TT_CHK_OBS_TT_EN
         obs_r   <= obs_s;
`endif
      end
   end

   assign stim     = stim_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign pass     = pass_r;
   assign err_cnt  = err_r;
   assign fail_idx = fidx_r;
   assign fail_vld = fvld_r;
`ifdef GATE_TT_CHK_OBS_TT_EN
   assign obs_tt   = obs_r;
`endif

endmodule
